// File: rtl/sdram_burst_dq_if.sv
// Controller-side handshake bundle for sdram_burst_dq.
// The command FSM (master) issues start pulses and supplies write beats;
// the datapath (slave) requests beats and returns read data and status.
interface sdram_burst_dq_if #(
    parameter int DATA_W = 16
);
    localparam int MASK_W = DATA_W / 8;

    logic              wr_start;
    logic              rd_start;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] wr_mask;
    logic              wr_data_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              burst_done;
    logic              err_overlap;

    modport master (
        output wr_start, rd_start, wr_data, wr_mask,
        input  wr_data_req, rd_data, rd_valid, busy, burst_done, err_overlap
    );

    modport slave (
        input  wr_start, rd_start, wr_data, wr_mask,
        output wr_data_req, rd_data, rd_valid, busy, burst_done, err_overlap
    );
endinterface

// File: rtl/sdram_burst_dq.sv
// Burst-capable SDRAM DQ datapath.
// Drives write bursts onto the tri-state DQ pins and captures read bursts
// after the CAS latency, counting beats locally so the command controller
// only has to issue single-cycle start pulses.
// Optional feature macro: SDRAM_DQ_BYTE_MASK_EN
//   defined   -> sdram_dqm carries the registered per-beat write mask
//   undefined -> sdram_dqm is tied low and wr_mask is ignored
module sdram_burst_dq #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 2,
    parameter int MASK_W    = DATA_W / 8
) (
    input  logic              clk_100m,
    input  logic              rst,
    sdram_burst_dq_if.slave   bus,
    inout  wire  [DATA_W-1:0] sdram_dq,
    output logic [MASK_W-1:0] sdram_dqm
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    // RD_WAIT lasts CAS_LAT-1 cycles, so it leaves when the counter reaches CAS_LAT-2
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CAS_LAT - 2);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        READ
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic              oe_r;
    logic [DATA_W-1:0] dq_out_r;
    logic              wr_req;

`ifdef SDRAM_DQ_BYTE_MASK_EN
    logic [MASK_W-1:0] dqm_r;
    assign sdram_dqm = dqm_r;
`else
    assign sdram_dqm = '0;
`endif

    // A beat is consumed on the start edge and on every WRITE edge except the last
    assign wr_req = ((state == IDLE) && bus.wr_start) ||
                    ((state == WRITE) && (beat_cnt != LAST_BEAT));
    assign bus.wr_data_req = wr_req;

    // The output enable only rises on a write-beat edge, so the pins float in every other state
    assign sdram_dq = oe_r ? dq_out_r : {DATA_W{1'bz}};

    // Burst sequencer: state, beat counter, write drivers and all registered status outputs
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            beat_cnt        <= '0;
            oe_r            <= 1'b0;
            dq_out_r        <= '0;
`ifdef SDRAM_DQ_BYTE_MASK_EN
            dqm_r           <= '0;
`endif
            bus.rd_data     <= '0;
            bus.rd_valid    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.burst_done  <= 1'b0;
            bus.err_overlap <= 1'b0;
        end else begin
            bus.rd_valid    <= 1'b0;
            bus.burst_done  <= 1'b0;
            bus.err_overlap <= 1'b0;

            if (wr_req) begin
                dq_out_r <= bus.wr_data;
                oe_r     <= 1'b1;
`ifdef SDRAM_DQ_BYTE_MASK_EN
                dqm_r    <= bus.wr_mask;
`endif
            end

            if ((state != IDLE) && (bus.wr_start || bus.rd_start)) begin
                bus.err_overlap <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.wr_start) begin
                        state           <= WRITE;
                        beat_cnt        <= '0;
                        bus.busy        <= 1'b1;
                        bus.err_overlap <= bus.rd_start;
                    end else if (bus.rd_start) begin
                        state    <= RD_WAIT;
                        beat_cnt <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                WRITE: begin
                    if (beat_cnt == LAST_BEAT) begin
                        state          <= IDLE;
                        beat_cnt       <= '0;
                        oe_r           <= 1'b0;
`ifdef SDRAM_DQ_BYTE_MASK_EN
                        dqm_r          <= '0;
`endif
                        bus.burst_done <= 1'b1;
                        bus.busy       <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (beat_cnt == WAIT_LAST) begin
                        state    <= READ;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                READ: begin
                    bus.rd_data  <= sdram_dq;
                    bus.rd_valid <= 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state          <= IDLE;
                        beat_cnt       <= '0;
                        bus.burst_done <= 1'b1;
                        bus.busy       <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_dq.sv
// Self-checking bench for sdram_burst_dq.
// Stimulus pushes expected pin activity, read beats, done and error pulses
// into per-cycle queues; a negedge monitor pops and compares them.
// Expected values follow the burst timing rules directly from the start cycle.
module tb_sdram_burst_dq;

    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 4;
    localparam int CAS_LAT   = 2;
    localparam int MASK_W    = DATA_W / 8;
`ifdef SDRAM_DQ_BYTE_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } beat_t;

    logic              clk_100m = 1'b0;
    logic              rst      = 1'b1;
    int                cyc      = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    wire  [DATA_W-1:0] sdram_dq;
    logic [MASK_W-1:0] sdram_dqm;
    logic              mdl_oe = 1'b0;
    logic [DATA_W-1:0] mdl_dq = '0;

    beat_t src_q[$];
    beat_t wr_q[$];
    beat_t drv_q[$];
    beat_t rd_q[$];
    int    done_q[$];
    int    err_q[$];

    int                busy_from = 0;
    int                busy_last = -1;
    logic              req_at_edge;
    logic [DATA_W-1:0] last_rd = '0;
    bit                mon_en = 1'b0;
    logic [DATA_W-1:0] stim_data [BURST_LEN];
    logic [MASK_W-1:0] stim_mask [BURST_LEN];

    logic              exp_drv;
    logic              exp_flag;
    logic [MASK_W-1:0] exp_mask;

    sdram_burst_dq_if #(.DATA_W(DATA_W)) bus ();

    assign sdram_dq = mdl_oe ? mdl_dq : {DATA_W{1'bz}};

    sdram_burst_dq #(
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN),
        .CAS_LAT  (CAS_LAT)
    ) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .bus      (bus),
        .sdram_dq (sdram_dq),
        .sdram_dqm(sdram_dqm)
    );

    // 100 MHz system clock
    always #5 clk_100m = ~clk_100m;

    // Cycle index: cycle k is the interval following the k-th rising edge
    always @(posedge clk_100m) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, actual, expected, cyc);
        end
    endtask

    task automatic presentSource();
        if (src_q.size() > 0) begin
            bus.wr_data = src_q[0].data;
            bus.wr_mask = src_q[0].mask;
        end else begin
            bus.wr_data = DATA_W'($urandom);
            bus.wr_mask = MASK_W'($urandom);
        end
    endtask

    // Advance one clock: retire consumed write beats and play the SDRAM read model
    task automatic tick();
        @(negedge clk_100m);
        req_at_edge = bus.wr_data_req;
        @(posedge clk_100m);
        #1;
        if (req_at_edge && src_q.size() > 0) src_q.delete(0);
        presentSource();
        if (drv_q.size() > 0 && drv_q[0].cyc == cyc) begin
            mdl_oe = 1'b1;
            mdl_dq = drv_q[0].data;
            drv_q.delete(0);
        end else begin
            mdl_oe = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic randomFill();
        for (int n = 0; n < BURST_LEN; n++) begin
            stim_data[n] = DATA_W'($urandom);
            stim_mask[n] = MASK_W'($urandom);
        end
    endtask

    // Issue starts for one cycle and record everything the datapath should do in response
    task automatic applyStimulus(input bit do_wr, input bit do_rd);
        int    c;
        bit    idle_now;
        beat_t b;
        c        = cyc;
        idle_now = (c > busy_last);
        bus.wr_start = do_wr;
        bus.rd_start = do_rd;
        if ((do_wr && do_rd) || ((do_wr || do_rd) && !idle_now)) err_q.push_back(c + 1);
        if (idle_now && do_wr) begin
            for (int n = 0; n < BURST_LEN; n++) begin
                b.cyc  = c + 1 + n;
                b.data = stim_data[n];
                b.mask = stim_mask[n];
                src_q.push_back(b);
                wr_q.push_back(b);
            end
            done_q.push_back(c + BURST_LEN + 1);
            busy_from = c + 1;
            busy_last = c + BURST_LEN;
            presentSource();
        end else if (idle_now && do_rd) begin
            for (int n = 0; n < BURST_LEN; n++) begin
                b.mask = '0;
                b.data = stim_data[n];
                b.cyc  = c + CAS_LAT + n;
                drv_q.push_back(b);
                b.cyc  = c + CAS_LAT + 1 + n;
                rd_q.push_back(b);
            end
            done_q.push_back(c + CAS_LAT + BURST_LEN);
            busy_from = c + 1;
            busy_last = c + CAS_LAT + BURST_LEN - 1;
        end
        tick();
        bus.wr_start = 1'b0;
        bus.rd_start = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dq_oe"},    dut.oe_r, 1'b0);
        checkOutput({tag, "_dqm"},      sdram_dqm, '0);
        checkOutput({tag, "_rd_data"},  bus.rd_data, '0);
        checkOutput({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
        checkOutput({tag, "_busy"},     bus.busy, 1'b0);
        checkOutput({tag, "_done"},     bus.burst_done, 1'b0);
        checkOutput({tag, "_err"},      bus.err_overlap, 1'b0);
    endtask

    // Monitor: compare every output against the scoreboard queues once per cycle
    always @(negedge clk_100m) begin
        if (mon_en && !rst) begin
            checkOutput("busy", bus.busy, (cyc >= busy_from) && (cyc <= busy_last));

            exp_flag = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            checkOutput("rd_valid", bus.rd_valid, exp_flag);
            if (exp_flag) begin
                checkOutput("rd_data", bus.rd_data, rd_q[0].data);
                last_rd = rd_q[0].data;
                rd_q.delete(0);
            end else begin
                checkOutput("rd_data_hold", bus.rd_data, last_rd);
            end

            exp_flag = (done_q.size() > 0) && (done_q[0] == cyc);
            checkOutput("burst_done", bus.burst_done, exp_flag);
            if (exp_flag) done_q.delete(0);

            exp_flag = (err_q.size() > 0) && (err_q[0] == cyc);
            checkOutput("err_overlap", bus.err_overlap, exp_flag);
            if (exp_flag) err_q.delete(0);

            exp_drv = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            checkOutput("dq_drive", dut.oe_r, exp_drv);
            exp_mask = '0;
            if (exp_drv) begin
                checkOutput("dq_data", sdram_dq, wr_q[0].data);
                if (MASK_EN) exp_mask = wr_q[0].mask;
                wr_q.delete(0);
            end
            checkOutput("dqm", sdram_dqm, exp_mask);
            if (mdl_oe) checkOutput("dq_read_bus", sdram_dq, mdl_dq);
        end
    end

    initial begin
        bus.wr_start = 1'b0;
        bus.rd_start = 1'b0;
        bus.wr_data  = '0;
        bus.wr_mask  = '0;

        // Reset state
        repeat (2) @(posedge clk_100m);
        #1;
        checkResetState("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        presentSource();
        idle(2);

        // Write burst with fixed pattern
        stim_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        stim_mask = '{2'b00, 2'b00, 2'b00, 2'b00};
        applyStimulus(1'b1, 1'b0);
        idle(6);

        // Read burst with fixed pattern
        stim_data = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        applyStimulus(1'b0, 1'b1);
        idle(8);

        // Both starts together: write only, read dropped
        randomFill();
        applyStimulus(1'b1, 1'b1);
        idle(6);

        // Read start during a write burst is ignored
        randomFill();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        idle(6);

        // Byte mask on beat 1 only
        stim_data = '{16'h5A5A, 16'hC3C3, 16'h0F0F, 16'hF0F0};
        stim_mask = '{2'b00, 2'b01, 2'b00, 2'b00};
        applyStimulus(1'b1, 1'b0);
        idle(6);

        // Reset during beat 2 of a write
        randomFill();
        applyStimulus(1'b1, 1'b0);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        checkResetState("midrst");
        src_q.delete();
        wr_q.delete();
        drv_q.delete();
        rd_q.delete();
        done_q.delete();
        err_q.delete();
        busy_last = cyc;
        last_rd   = '0;
        mdl_oe    = 1'b0;
        presentSource();
        @(posedge clk_100m);
        #1;
        rst = 1'b0;
        idle(1);
        randomFill();
        applyStimulus(1'b1, 1'b0);
        idle(6);

        // Randomized traffic including overlapping and simultaneous starts
        for (int i = 0; i < 400; i++) begin
            int r;
            randomFill();
            r = int'($urandom_range(0, 7));
            applyStimulus((r == 0) || (r == 2), (r == 1) || (r == 2));
        end
        idle(12);

        checkOutput("wr_q_empty",   wr_q.size(),   0);
        checkOutput("rd_q_empty",   rd_q.size(),   0);
        checkOutput("done_q_empty", done_q.size(), 0);
        checkOutput("err_q_empty",  err_q.size(),  0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
